// File: rtl/elevator_pkg.sv
//----------------------------------------------------------------------------
// elevator_pkg : shared states, floor defaults and one-hot helper
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam int DEF_NUM_FLOORS = 3;
  localparam int DEF_FLOOR_W    = 2;
  localparam int MAX_FLOORS     = 32;

  // Callers size-cast the result down to their own floor count.
  function automatic logic [MAX_FLOORS-1:0] onehot_from_index(input int unsigned idx);
    logic [MAX_FLOORS-1:0] v;
    v = (idx < MAX_FLOORS) ? (MAX_FLOORS'(1) << idx) : '0;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_scan_select.sv
//----------------------------------------------------------------------------
// elevator_scan_select : combinational SCAN target picker
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module elevator_scan_select
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic                  sel_valid,
  output logic [FLOOR_W-1:0]    sel_floor,
  output logic                  sel_dir_up
);

  logic               here_hit;
  logic               above_hit;
  logic               below_hit;
  logic [FLOOR_W-1:0] above_floor;
  logic [FLOOR_W-1:0] below_floor;

  always_comb begin
    here_hit    = 1'b0;
    above_hit   = 1'b0;
    below_hit   = 1'b0;
    above_floor = '0;
    below_floor = '0;
    // Ascending scan: first hit above is nearest, last hit below is nearest.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i == int'(current_floor)) begin
          here_hit = 1'b1;
        end else if (i > int'(current_floor)) begin
          if (!above_hit) begin
            above_hit   = 1'b1;
            above_floor = FLOOR_W'(i);
          end
        end else begin
          below_hit   = 1'b1;
          below_floor = FLOOR_W'(i);
        end
      end
    end

    sel_valid  = |pending;
    sel_floor  = current_floor;
    sel_dir_up = dir_up;
    if (!here_hit) begin
      if (dir_up) begin
        if (above_hit) begin
          sel_floor = above_floor;
        end else if (below_hit) begin
          sel_floor  = below_floor;
          sel_dir_up = 1'b0;
        end
      end else begin
        if (below_hit) begin
          sel_floor = below_floor;
        end else if (above_hit) begin
          sel_floor  = above_floor;
          sel_dir_up = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
//----------------------------------------------------------------------------
// elevator_request_scheduler : latches calls, drives lift targets in SCAN order
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W,
  parameter int DOOR_HOLD  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  input  logic                  moving,
  output logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy,
  output logic                  fault
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int HOLD_W = $clog2(DOOR_HOLD + 1);

  state_t                  state, state_n;
  logic [NUM_FLOORS-1:0]   req_n, pending_n, set_mask, clear_mask, target_mask;
  logic [FLOOR_W-1:0]      target_n;
  logic                    dir_n;
  logic [TCNT_W-1:0]       tcnt, tcnt_n;
  logic [HOLD_W-1:0]       hold, hold_n;
  logic                    sel_valid, sel_dir_up;
  logic [FLOOR_W-1:0]      sel_floor;
  logic                    out_of_range, arrived;
  logic                    unused_moving;

  assign unused_moving = moving;

  elevator_scan_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_select (
    .pending       (pending),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .sel_valid     (sel_valid),
    .sel_floor     (sel_floor),
    .sel_dir_up    (sel_dir_up)
  );

  assign out_of_range = (int'(current_floor) >= NUM_FLOORS);
  assign arrived      = (current_floor == target_floor) && door_open;
  assign target_mask  = NUM_FLOORS'(onehot_from_index(32'(target_floor)));
  assign busy         = (state != ST_IDLE);
  assign fault        = (state == ST_FAULT);

  always_comb begin
    state_n    = state;
    req_n      = req;
    target_n   = target_floor;
    dir_n      = dir_up;
    tcnt_n     = tcnt;
    hold_n     = hold;
    set_mask   = call_btn;
    clear_mask = '0;

    unique case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_n  = ST_MOVE;
          target_n = sel_floor;
          dir_n    = sel_dir_up;
          req_n    = NUM_FLOORS'(onehot_from_index(32'(sel_floor)));
          tcnt_n   = '0;
        end
      end
      ST_MOVE: begin
        if (out_of_range) begin
          state_n = ST_FAULT;
          req_n   = '0;
        end else if (arrived) begin
          state_n    = ST_SERVICE;
          req_n      = '0;
          clear_mask = target_mask;
          hold_n     = HOLD_W'(DOOR_HOLD - 1);
        end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          state_n = ST_FAULT;
          req_n   = '0;
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
      end
      ST_SERVICE: begin
        // Presses for the floor being served are swallowed while the door is held.
        set_mask = call_btn & ~target_mask;
        if (out_of_range) begin
          state_n = ST_FAULT;
          req_n   = '0;
        end else if (hold == '0) begin
          state_n = ST_IDLE;
        end else begin
          hold_n = hold - HOLD_W'(1);
        end
      end
      ST_FAULT: begin
        req_n = '0;
      end
    endcase

    pending_n = (pending | set_mask) & ~clear_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req          <= '0;
      target_floor <= '0;
      pending      <= '0;
      dir_up       <= 1'b1;
      tcnt         <= '0;
      hold         <= '0;
    end else begin
      state        <= state_n;
      req          <= req_n;
      target_floor <= target_n;
      pending      <= pending_n;
      dir_up       <= dir_n;
      tcnt         <= tcnt_n;
      hold         <= hold_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
//----------------------------------------------------------------------------
// tb_elevator_request_scheduler : directed + random bench with behavioural model
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_elevator_request_scheduler;

  localparam int NF = 3;
  localparam int FW = 2;
  localparam int DH = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_btn;
  logic [FW-1:0] current_floor;
  logic          door_open;
  logic          moving;
  logic [NF-1:0] req;
  logic [FW-1:0] target_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          busy;
  logic          fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 waiting, 1 travelling, 2 door held, 3 faulted.
  int      m_phase;
  bit [NF-1:0] m_pend;
  int      m_tgt;
  bit      m_up;
  int      m_ticks;

  elevator_request_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (FW),
    .DOOR_HOLD  (DH),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .call_btn      (call_btn),
    .current_floor (current_floor),
    .door_open     (door_open),
    .moving        (moving),
    .req           (req),
    .target_floor  (target_floor),
    .pending       (pending),
    .dir_up        (dir_up),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // SCAN choice by distance: same floor, else nearest ahead, else nearest behind with a flip.
  task automatic pick(input bit [NF-1:0] p, input int cur, input bit up,
                      output int tgt, output bit nup);
    int ahead;
    int behind;
    ahead  = -1;
    behind = -1;
    nup    = up;
    tgt    = 0;
    if (cur < NF && p[cur]) begin
      tgt = cur;
    end else begin
      for (int f = 0; f < NF; f++) begin
        if (p[f]) begin
          if ((up && f > cur) || (!up && f < cur)) begin
            if (ahead < 0 || iabs(f - cur) < iabs(ahead - cur)) ahead = f;
          end else begin
            if (behind < 0 || iabs(f - cur) < iabs(behind - cur)) behind = f;
          end
        end
      end
      if (ahead >= 0) begin
        tgt = ahead;
      end else begin
        tgt = behind;
        nup = !up;
      end
    end
  endtask

  task automatic model_edge();
    bit [NF-1:0] press;
    bit [NF-1:0] clr;
    int          cur;
    int          t;
    bit          u;
    cur   = int'(current_floor);
    press = call_btn;
    clr   = '0;
    if (reset) begin
      m_phase = 0; m_pend = '0; m_tgt = 0; m_up = 1'b1; m_ticks = 0;
      return;
    end
    case (m_phase)
      0: if (m_pend != 0) begin
           pick(m_pend, cur, m_up, t, u);
           m_tgt = t; m_up = u; m_phase = 1; m_ticks = 0;
         end
      1: begin
           m_ticks++;
           if (cur >= NF) m_phase = 3;
           else if (cur == m_tgt && door_open) begin
             m_phase = 2; m_ticks = 0; clr[m_tgt] = 1'b1;
           end else if (m_ticks == TO) m_phase = 3;
         end
      2: begin
           press[m_tgt] = 1'b0;
           m_ticks++;
           if (cur >= NF) m_phase = 3;
           else if (m_ticks == DH) m_phase = 0;
         end
      default: ;
    endcase
    m_pend = (m_pend | press) & ~clr;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("req",     int'(req),          (m_phase == 1) ? (1 << m_tgt) : 0);
    chk("pending", int'(pending),      int'(m_pend));
    chk("target",  int'(target_floor), m_tgt);
    chk("dir_up",  int'(dir_up),       int'(m_up));
    chk("busy",    int'(busy),         (m_phase != 0) ? 1 : 0);
    chk("fault",   int'(fault),        (m_phase == 3) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; call_btn = '0; current_floor = '0; door_open = 1'b0; moving = 1'b0;
    m_phase = 0; m_pend = '0; m_tgt = 0; m_up = 1'b1; m_ticks = 0;
    step();
    chk("rst_dir_up", int'(dir_up), 1);
    reset = 1'b0;

    // Single call to floor 1 from floor 0
    call_btn = 3'b010; step();
    call_btn = 3'b000; step();
    chk("single_req", int'(req), 3'b010);
    current_floor = 2'd1; door_open = 1'b1; step();
    chk("single_arr_req", int'(req), 0);
    chk("single_arr_pend", int'(pending), 0);
    repeat (DH) step();
    chk("single_idle", int'(busy), 0);
    door_open = 1'b0;

    // SCAN: at floor 1 going up with {0,2} pending
    call_btn = 3'b101; step();
    call_btn = 3'b000; step();
    chk("scan_first", int'(target_floor), 2);
    current_floor = 2'd2; door_open = 1'b1; step();
    repeat (DH) step();
    door_open = 1'b0; step();
    chk("scan_second", int'(target_floor), 0);
    chk("scan_dir", int'(dir_up), 0);
    current_floor = 2'd0; door_open = 1'b1; step();
    repeat (DH) step();

    // Call for the floor the lift is already at
    current_floor = 2'd2; call_btn = 3'b100; step();
    call_btn = 3'b000; step();
    chk("here_move", int'(req), 3'b100);
    step();
    chk("here_service", int'(busy & ~(|req)), 1);
    chk("here_dir", int'(dir_up), 0);
    repeat (DH) step();

    // Held press for the floor in service
    current_floor = 2'd1; call_btn = 3'b010;
    step(); step(); step();
    chk("coll_clear", int'(pending), 0);
    repeat (DH) step();
    chk("coll_masked", int'(pending), 0);
    step();
    chk("coll_reset", int'(pending), 3'b010);
    call_btn = 3'b000;
    step(); step();
    repeat (DH) step();
    door_open = 1'b0;

    // Reset in the middle of a trip
    current_floor = 2'd0; call_btn = 3'b100; step();
    call_btn = 3'b000; step();
    chk("rmid_req", int'(req), 3'b100);
    reset = 1'b1; step();
    chk("rmid_req0", int'(req), 0);
    reset = 1'b0; call_btn = 3'b001; step();
    chk("rmid_accept", int'(pending), 3'b001);
    call_btn = 3'b000;

    // Timeout with the lift parked at floor 0
    reset = 1'b1; step(); reset = 1'b0;
    call_btn = 3'b100; step();
    call_btn = 3'b000; step();
    repeat (TO - 1) step();
    chk("to_early", int'(fault), 0);
    step();
    chk("to_fault", int'(fault), 1);
    call_btn = 3'b001; step();
    call_btn = 3'b000;
    repeat (4) step();
    chk("to_sticky", int'(fault), 1);

    // Out-of-range position while travelling
    reset = 1'b1; step(); reset = 1'b0;
    call_btn = 3'b100; step();
    call_btn = 3'b000; step();
    current_floor = 2'd3; step();
    chk("oor_fault", int'(fault), 1);
    current_floor = 2'd0; reset = 1'b1; step(); reset = 1'b0;

    // Random traffic with an occasionally cooperative lift
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      call_btn = ($urandom_range(0, 3) == 0) ? NF'($urandom_range(0, 7)) : '0;
      if (m_phase == 1 && $urandom_range(0, 2) == 0) current_floor = FW'(m_tgt);
      else if ($urandom_range(0, 4) == 0) current_floor = FW'($urandom_range(0, NF - 1));
      door_open = ($urandom_range(0, 1) == 1);
      moving    = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Request scheduler sitting between the floor call buttons and `Elevator_lift`. It latches call presses into a pending set and picks one target floor at a time using SCAN (continue in current direction, reverse only when nothing remains ahead). It drives the lift's one-hot `req` input and watches `current_floor` and `door_open` to retire each request. It holds the door-service window and raises a sticky fault if the lift never arrives.

## Interface
- `NUM_FLOORS`, 3: floors served; `req`, `pending` and `call_btn` are this wide.
- `FLOOR_W`, 2: width of the floor index; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- `DOOR_HOLD`, 4: cycles spent in SERVICE after arrival (>=1).
- `TIMEOUT`, 64: max cycles in MOVE before FAULT (>=2).
- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `call_btn` in NUM_FLOORS: call requests, any bit pattern, level or pulse.
- `current_floor` in FLOOR_W: lift position.
- `door_open` in 1: lift door status.
- `moving` in 1: lift in motion (status only; not used for decisions).
- `req` out NUM_FLOORS: one-hot target to lift, or all-zero.
- `target_floor` out FLOOR_W: index of the active target.
- `pending` out NUM_FLOORS: latched outstanding calls.
- `dir_up` out 1: SCAN direction, 1 = up.
- `busy` out 1: state != IDLE.
- `fault` out 1: sticky, cleared only by reset.

## Operation
- Reset values:
  - `pending`=0, `req`=0, `target_floor`=0, `dir_up`=1, `busy`=0, `fault`=0.
  - State IDLE, both counters 0.
- Pending set: any `call_btn` bit high at a posedge sets the matching `pending` bit.
- Pending clear: the target bit is cleared on the transition MOVE→SERVICE.
- Set/clear collision: if set and clear hit the same bit in the same cycle, clear wins. A press for the floor being served while in SERVICE is ignored.
- Selection (combinational, from registered `pending`, `current_floor`, `dir_up`):
  - If a pending floor equals `current_floor`, select it.
  - Else, if `dir_up`, select the nearest pending floor above; if none, the nearest below and flip `dir_up`.
  - Mirror image when `dir_up`=0.
  - The direction flip is registered together with the target.
- States:
  - IDLE:
    - If `pending`!=0, go to MOVE: register `target_floor`, drive `req`=one-hot(target), clear the timeout counter.
  - MOVE:
    - Hold `req` and `target_floor` stable.
    - Arrival (`current_floor`==`target_floor` and `door_open`=1): go to SERVICE, `req`=0, clear the pending bit, load the hold counter.
    - Timeout counter reaches TIMEOUT-1 without arrival: go to FAULT.
  - SERVICE:
    - Count down DOOR_HOLD cycles.
    - At expiry go to IDLE. Selection then runs from IDLE on the next cycle.
  - FAULT:
    - `req`=0, `fault`=1, `busy`=1.
    - `pending` keeps accumulating.
    - Exit only by reset.
- Out-of-range position: `current_floor` >= NUM_FLOORS sampled in any state other than IDLE forces FAULT on the next edge.
- New calls while in MOVE never retarget the current trip. They are considered at the next IDLE selection.

## Timing
- `call_btn` sampled at edge N → `pending` visible after N.
- `req` is asserted after edge N+1, provided the scheduler was IDLE.
- Arrival sampled at edge M:
  - `req`=0 and `pending` bit clear after M.
  - State returns to IDLE after edge M+DOOR_HOLD.
  - The next `req` is asserted after edge M+DOOR_HOLD+1.
- Timeout: FAULT is entered at the TIMEOUT-th edge after MOVE entry, counting the entry edge as 0.
- All outputs are registered; no combinational input→output path.
- Reset asserted mid-trip: the next edge restores all reset values. `req` drops in the same cycle it is seen.

## Structure
- Shared package `elevator_pkg`: state enum (IDLE, MOVE, SERVICE, FAULT), default NUM_FLOORS/FLOOR_W, and a one-hot-from-index function. The same package is reused by `Elevator_lift` users.
- One sub-module `elevator_scan_select` (combinational). Inputs: `pending`, `current_floor`, `dir_up`. Outputs: `sel_valid`, `sel_floor`, `sel_dir_up`.
- Top: FSM, pending register, hold counter, timeout counter.

## Test plan
- **Single call:**
  - Stimulus: reset, `current_floor`=0, press `call_btn`=3'b010 for 1 cycle.
  - Response: `req`=3'b010 two edges later.
  - Then model `current_floor`=1, `door_open`=1: `req`=0, `pending`=0, `busy` low after DOOR_HOLD more edges.
- **SCAN order:**
  - Stimulus: at floor 1 going up, pending {0,2}.
  - Response: floor 2 served first, then `dir_up`=0 and floor 0 served.
- **Current-floor call:**
  - Stimulus: in IDLE at floor 2, press floor 2, `door_open`=1.
  - Response: MOVE lasts one cycle, SERVICE follows, `dir_up` unchanged.
- **Collision:**
  - Stimulus: in SERVICE at floor 1, hold `call_btn`[1]=1 throughout.
  - Response: bit 1 is cleared at arrival and re-set one edge after SERVICE; no spurious retarget during SERVICE.
- **Timeout:**
  - Stimulus: request floor 2, never change `current_floor`.
  - Response: `fault`=1 and `req`=0 after TIMEOUT edges; stays set until reset.
  - Then `current_floor`=3 case: FAULT on the next edge.
- **Reset mid-MOVE:**
  - Stimulus: assert `reset` for one cycle while `req`=3'b100.
  - Response: all outputs at reset values after that edge; new presses are accepted on the following edge.
